// File: rtl/reaction_timer_if.sv
// Signal bundle between the reaction-time controller and its surroundings:
// LFSR sample, player/timebase inputs, and the display-facing result outputs.
interface reaction_timer_if #(
  parameter int RES_W = 8
) ();
  logic [4:0]       rnd;
  logic             start;
  logic             btn;
  logic             tick;
  logic             led;
  logic             busy;
  logic [RES_W-1:0] result;
  logic             result_valid;
  logic             false_start;
  logic             too_slow;

  modport master (
    output rnd, start, btn, tick,
    input  led, busy, result, result_valid, false_start, too_slow
  );

  modport slave (
    input  rnd, start, btn, tick,
    output led, busy, result, result_valid, false_start, too_slow
  );
endinterface

// File: rtl/reaction_timer.sv
// Reaction-time game controller: random wait, LED stimulus, tick-counted
// reaction measurement with false-start and timeout detection.
module reaction_timer #(
  parameter int MIN_DELAY = 4,
  parameter int RES_W     = 8,
  parameter int TIMEOUT   = 255
) (
  input logic             clk,
  input logic             rst,
  reaction_timer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ARMED = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [5:0]       MIN_DELAY_W = 6'(MIN_DELAY);
  localparam logic [RES_W-1:0] TIMEOUT_W   = RES_W'(TIMEOUT);
  localparam logic [RES_W-1:0] ONE_W       = RES_W'(1'b1);
  localparam logic [RES_W-1:0] ZERO_W      = {RES_W{1'b0}};

  state_t           state_r, state_s;
  logic [5:0]       delay_cnt_r, delay_cnt_s;
  logic [RES_W-1:0] react_cnt_r, react_cnt_s;
  logic [RES_W-1:0] react_inc_s;
  logic [RES_W-1:0] result_r, result_s;
  logic             result_valid_r, result_valid_s;
  logic             false_start_r, false_start_s;
  logic             too_slow_r, too_slow_s;
  logic             led_r, led_s;
  logic             busy_r, busy_s;
  logic             start_q_r, btn_q_r;
  logic             start_edge_s, btn_edge_s;

  // Only fresh rising edges count; a level held across a state change is inert.
  always_comb begin
    start_edge_s = bus.start & ~start_q_r;
    btn_edge_s   = bus.btn & ~btn_q_r;
    react_inc_s  = react_cnt_r + ONE_W;
  end

  // Input history registers for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q_r <= 1'b0;
      btn_q_r   <= 1'b0;
    end else begin
      start_q_r <= bus.start;
      btn_q_r   <= bus.btn;
    end
  end

  // Next-state, counter and output computation.
  always_comb begin
    state_s        = state_r;
    delay_cnt_s    = delay_cnt_r;
    react_cnt_s    = react_cnt_r;
    result_s       = result_r;
    result_valid_s = result_valid_r;
    false_start_s  = false_start_r;
    too_slow_s     = too_slow_r;

    case (state_r)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start_edge_s) begin
          state_s        = ST_WAIT;
          delay_cnt_s    = {1'b0, bus.rnd} + MIN_DELAY_W;
          result_s       = ZERO_W;
          result_valid_s = 1'b0;
          false_start_s  = 1'b0;
          too_slow_s     = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_WAIT: begin
        // A press on the final wait tick is still a false start.
        if (btn_edge_s) begin
          state_s       = ST_FAULT;
          false_start_s = 1'b1;
        end else if (bus.tick) begin
          if (delay_cnt_r <= 6'd1) begin
            state_s     = ST_ARMED;
            delay_cnt_s = 6'd0;
            react_cnt_s = ZERO_W;
          end else begin
            delay_cnt_s = delay_cnt_r - 6'd1;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ARMED: begin
        // The press beats a coincident tick, so that tick is never counted.
        if (btn_edge_s) begin
          state_s        = ST_DONE;
          result_s       = react_cnt_r;
          result_valid_s = 1'b1;
        end else if (bus.tick) begin
          react_cnt_s = react_inc_s;
          if (react_inc_s == TIMEOUT_W) begin
            state_s    = ST_DONE;
            result_s   = TIMEOUT_W;
            too_slow_s = 1'b1;
          end else begin
            state_s = ST_ARMED;
          end
        end else begin
          state_s = ST_ARMED;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    led_s  = (state_s == ST_ARMED);
    busy_s = (state_s == ST_WAIT) || (state_s == ST_ARMED);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      delay_cnt_r    <= 6'd0;
      react_cnt_r    <= ZERO_W;
      result_r       <= ZERO_W;
      result_valid_r <= 1'b0;
      false_start_r  <= 1'b0;
      too_slow_r     <= 1'b0;
      led_r          <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      delay_cnt_r    <= delay_cnt_s;
      react_cnt_r    <= react_cnt_s;
      result_r       <= result_s;
      result_valid_r <= result_valid_s;
      false_start_r  <= false_start_s;
      too_slow_r     <= too_slow_s;
      led_r          <= led_s;
      busy_r         <= busy_s;
    end
  end

  assign bus.led          = led_r;
  assign bus.busy         = busy_r;
  assign bus.result       = result_r;
  assign bus.result_valid = result_valid_r;
  assign bus.false_start  = false_start_r;
  assign bus.too_slow     = too_slow_r;

endmodule

// File: tb/tb_reaction_timer.sv
// Randomized bench for reaction_timer: attempt outcomes come from a
// tick-count model and are checked by a monitor when busy falls.
module tb_reaction_timer;

  localparam int MIN_DELAY = 4;
  localparam int RES_W     = 8;
  localparam int TIMEOUT   = 20;

  typedef struct {
    int res;
    int valid;
    int fs;
    int ts;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  exp_t exp_q[$];
  logic prev_busy;

  reaction_timer_if #(.RES_W(RES_W)) bus ();

  reaction_timer #(
    .MIN_DELAY(MIN_DELAY),
    .RES_W    (RES_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: every busy 1->0 transition presents one outcome to score.
  always @(negedge clk) begin
    if (prev_busy && !bus.busy) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_outcome: got result %0d with empty queue", bus.result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 32'(bus.result), 32'(e.res));
        chk("result_valid", 32'(bus.result_valid), 32'(e.valid));
        chk("false_start", 32'(bus.false_start), 32'(e.fs));
        chk("too_slow", 32'(bus.too_slow), 32'(e.ts));
        chk("led_at_end", 32'(bus.led), 32'd0);
      end
    end
    prev_busy = bus.busy;
  end

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // One attempt. press_n = ticks seen before the press (-1: never press);
  // coincide puts the press in the same cycle as tick press_n+1.
  task automatic run_attempt(input logic [4:0] r, input int press_n, input bit coincide,
                             input bit hold_btn, input bit stray);
    int   w;
    int   limit;
    bit   do_press;
    exp_t e;
    w = int'(r) + MIN_DELAY;
    if (press_n < 0 || press_n - w >= TIMEOUT) begin
      do_press = 1'b0;
      limit    = w + TIMEOUT;
      e = '{res: TIMEOUT, valid: 0, fs: 0, ts: 1};
    end else if (press_n < w) begin
      do_press = 1'b1;
      limit    = press_n;
      e = '{res: 0, valid: 0, fs: 1, ts: 0};
    end else begin
      do_press = 1'b1;
      limit    = press_n;
      e = '{res: press_n - w, valid: 1, fs: 0, ts: 0};
    end
    exp_q.push_back(e);

    bus.rnd   = r;
    bus.start = 1'b1;
    bus.btn   = hold_btn;
    bus.tick  = 1'b0;
    step();
    bus.start = 1'b0;
    bus.rnd   = 5'($urandom);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("result_cleared", 32'(bus.result), 32'd0);
    chk("valid_cleared", 32'(bus.result_valid), 32'd0);
    chk("fs_cleared", 32'(bus.false_start), 32'd0);
    chk("ts_cleared", 32'(bus.too_slow), 32'd0);
    if (hold_btn) step();
    bus.btn = 1'b0;
    step();

    for (int t = 0; ; t++) begin
      if (do_press && !coincide && t == press_n) begin
        bus.btn = 1'b1;
        step();
        break;
      end
      if (!do_press && t == limit) break;
      repeat ($urandom_range(0, 2)) begin
        bus.start = stray && ($urandom_range(0, 1) == 1);
        step();
        bus.start = 1'b0;
      end
      if (t == w - 1) chk("led_low_before_arm", 32'(bus.led), 32'd0);
      bus.tick = 1'b1;
      if (do_press && coincide && t == press_n) bus.btn = 1'b1;
      step();
      bus.tick = 1'b0;
      if (do_press && coincide && t == press_n) break;
      if (t + 1 == w) chk("led_high_after_arm", 32'(bus.led), 32'd1);
    end
    step();
    bus.btn = 1'b0;
    step();
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    prev_busy = 1'b0;
    bus.rnd   = 5'd0;
    bus.start = 1'b1;
    bus.btn   = 1'b1;
    bus.tick  = 1'b0;
    rst       = 1'b0;
    repeat (3) step();
    chk("rst_led", 32'(bus.led), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_fs", 32'(bus.false_start), 32'd0);
    chk("rst_ts", 32'(bus.too_slow), 32'd0);
    bus.start = 1'b0;
    bus.btn   = 1'b0;
    step();
    rst = 1'b1;
    bus.tick = 1'b1;
    repeat (4) step();
    bus.tick = 1'b0;
    chk("idle_without_start", 32'(bus.busy), 32'd0);

    // Normal attempt: wait 7, press after 12 armed ticks.
    run_attempt(5'b00011, 7 + 12, 1'b0, 1'b0, 1'b0);
    // A press while DONE is ignored.
    bus.btn = 1'b1;
    step();
    bus.btn = 1'b0;
    step();
    chk("done_btn_ignored_result", 32'(bus.result), 32'd12);
    chk("done_btn_ignored_valid", 32'(bus.result_valid), 32'd1);
    chk("done_btn_ignored_busy", 32'(bus.busy), 32'd0);

    // False start after tick 5 of a 32-tick wait.
    run_attempt(5'b11100, 5, 1'b0, 1'b0, 1'b0);
    // Press on the final wait tick; press on an armed tick with react_cnt 9.
    run_attempt(5'b00101, 9 - 1, 1'b1, 1'b0, 1'b0);
    run_attempt(5'b01010, 14 + 9, 1'b1, 1'b0, 1'b0);
    // Timeout, held button across start, stray starts mid-attempt.
    run_attempt(5'b00001, -1, 1'b0, 1'b0, 1'b1);
    run_attempt(5'b00110, 10 + 3, 1'b0, 1'b1, 1'b1);

    // Reset while ARMED with rnd=0 (4-tick wait).
    bus.rnd   = 5'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.tick  = 1'b1;
    repeat (7) step();
    bus.tick = 1'b0;
    chk("armed_before_rst_led", 32'(bus.led), 32'd1);
    exp_q.push_back('{res: 0, valid: 0, fs: 0, ts: 0});
    rst = 1'b0;
    #1;
    chk("async_led_drop", 32'(bus.led), 32'd0);
    chk("async_busy_drop", 32'(bus.busy), 32'd0);
    step();
    rst = 1'b1;
    drain();

    for (int k = 0; k < 30; k++) begin
      logic [4:0] r;
      int         pn;
      r  = 5'($urandom);
      pn = ($urandom_range(0, 5) == 0) ? -1
           : int'($urandom_range(0, int'(r) + MIN_DELAY + TIMEOUT + 2));
      run_attempt(r, pn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Reaction-time game controller that sits directly downstream of the 5-bit LFSR and consumes its `rnd` output.
- On a start request it samples `rnd` to pick a random wait. After the wait it lights the LED, then measures how many ticks pass before the player presses the button.
- Detects false starts (button pressed before the LED) and timeouts (no press in time).
- Output feeds the display/score logic.

Parameters:
- MIN_DELAY, 4: constant added to the sampled random value; wait length in ticks = rnd + MIN_DELAY.
- RES_W, 8: width of the reaction counter and `result`.
- TIMEOUT, 255: reaction tick count at which the attempt is aborted as too slow; must be ≤ 2^RES_W−1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rnd  in  5  random value from the upstream LFSR; sampled only on an accepted start.
- start  in  1  start request level, synchronous to clk; a rising edge is detected internally.
- btn  in  1  player button level, synchronous to clk; a rising edge is detected internally.
- tick  in  1  one-cycle timebase strobe (e.g. 1 ms); all timing counts tick strobes.
- led  out  1  stimulus LED; high only in ARMED.
- busy  out  1  high in WAIT and ARMED.
- result  out  RES_W  measured reaction in ticks.
- result_valid  out  1  high when `result` holds a valid measurement.
- false_start  out  1  button was pressed during WAIT.
- too_slow  out  1  TIMEOUT was reached without a press.

Behaviour:
- Reset (asynchronous, rst=0):
  - State is IDLE.
  - led, busy, result, result_valid, false_start and too_slow are all 0.
  - Internal delay_cnt, react_cnt and both edge-detect history registers are 0.
- Edge detect:
  - start_edge = start & ~start_q; btn_edge = btn & ~btn_q. start_q and btn_q are registered every cycle.
  - A button held across a state change does not produce an edge; only a fresh press counts.
- States: IDLE, WAIT, ARMED, DONE, FAULT. All outputs are registered.
- IDLE / DONE / FAULT:
  - start_edge in cycle N captures delay_cnt = rnd + MIN_DELAY in cycle N, computed at 6-bit width with no overflow.
  - It also clears result, result_valid, false_start and too_slow.
  - The next state is WAIT, so busy=1 from cycle N+1.
  - btn_edge is ignored in these states.
- WAIT:
  - Each tick decrements delay_cnt.
  - A tick with delay_cnt==1 (or delay_cnt==0, defensive) moves to ARMED with react_cnt=0; led goes high the following cycle.
  - btn_edge moves to FAULT with false_start=1 and busy=0.
  - If btn_edge and the final tick fall in the same cycle, the false start wins.
- ARMED:
  - Each tick increments react_cnt.
  - btn_edge moves to DONE with result=react_cnt (the value before any same-cycle tick), result_valid=1 and led=0. If btn_edge and tick coincide, the press wins and the tick is not counted.
  - A tick that would make react_cnt==TIMEOUT, with no press, moves to DONE with result=TIMEOUT, too_slow=1, result_valid=0 and led=0.
- start_edge is ignored in WAIT and ARMED; a restart mid-attempt is not possible.
- result and the flags hold in DONE and FAULT until the next accepted start.
- Reset asserted mid-attempt returns immediately to reset values, and led drops asynchronously.
- rnd=0 is legal, though the LFSR never produces it; the wait is then MIN_DELAY ticks.
- If MIN_DELAY=0 and rnd=0, the first tick in WAIT arms.

Test Plan:
- Reset with start=1 and btn=1 held: all outputs 0 and state IDLE. Releasing and pressing start again is then required before any activity occurs.
- Normal attempt: rnd=5'b00011, MIN_DELAY=4 gives a 7-tick wait. led rises the cycle after the 7th tick. btn_edge after 12 ARMED ticks gives result=12, result_valid=1, led=0, busy=0.
- False start: rnd=5'b11100 (wait 32). btn_edge after tick 5 gives false_start=1, led never high, result_valid=0, busy=0.
- Coincidence cases:
  - btn_edge in the same cycle as the final WAIT tick gives FAULT.
  - btn_edge in the same cycle as an ARMED tick with react_cnt=9 gives result=9.
- Timeout: TIMEOUT=20 and no press. After 20 ARMED ticks: too_slow=1, result=20, result_valid=0, led=0.
- Restart/ignore:
  - start_edge in WAIT or ARMED has no effect.
  - start_edge in DONE clears all flags and a new rnd is sampled.
  - rst pulsed low in ARMED forces led=0 and IDLE immediately.
